// File: rtl/heartbeat_monitor_pkg.sv
// Shared types and helpers for the heartbeat watchdog and its sub-blocks.
package heartbeat_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_ALIVE   = 2'd2,
        ST_FAULT   = 2'd3
    } hb_state_t;

    typedef logic [1:0] fault_code_t;

    localparam fault_code_t FC_NONE    = 2'b00;
    localparam fault_code_t FC_FAST    = 2'b01;
    localparam fault_code_t FC_TIMEOUT = 2'b10;

    // Bits needed to hold values 0..value-1; never narrower than one bit.
    function automatic int clog2(input int unsigned value);
        int          result;
        int unsigned rem;
        result = 0;
        rem    = (value > 0) ? value - 1 : 0;
        while (rem != 0) begin
            rem    = rem >> 1;
            result = result + 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/heartbeat_monitor_if.sv
// Heartbeat watchdog signal bundle: heartbeat/clear in, status out.
interface heartbeat_monitor_if;
    import heartbeat_monitor_pkg::*;

    logic        iHeartBeat;
    logic        iClear;
    logic        oAlive;
    logic        oFault;
    fault_code_t oFaultCode;
    logic        oEdgePulse;

    modport master (
        output iHeartBeat, iClear,
        input  oAlive, oFault, oFaultCode, oEdgePulse
    );

    modport slave (
        input  iHeartBeat, iClear,
        output oAlive, oFault, oFaultCode, oEdgePulse
    );

endinterface

// File: rtl/hb_edge_sync.sv
// Two-flop synchronizer plus delay flop; emits a registered one-cycle pulse
// for every level change of a slow asynchronous input.
module hb_edge_sync (
    input  logic iClk,
    input  logic iRst,
    input  logic i_async,
    output logic o_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync3;
    logic r_pulse;
    logic w_toggle;

    assign w_toggle = r_sync2 ^ r_sync3;
    assign o_pulse  = r_pulse;

    // NOTE: non-blocking assignments make the three flops a true shift chain.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_pulse <= w_toggle;
        end
    end

endmodule

// File: rtl/heartbeat_monitor.sv
// Heartbeat watchdog: measures half-periods of a synchronized heartbeat,
// declares it alive after a run of legal intervals, latches sticky faults.
module heartbeat_monitor
    import heartbeat_monitor_pkg::*;
#(
    parameter int MIN_HALF = 200000,
    parameter int MAX_HALF = 300000,
    parameter int GOOD_CNT = 4
) (
    input  logic                iClk,
    input  logic                iRst,
    heartbeat_monitor_if.slave  hb
);

    localparam int CNT_W  = clog2(MAX_HALF + 1);
    localparam int GOOD_W = clog2(GOOD_CNT + 1);

    localparam logic [CNT_W-1:0]  MIN_C     = CNT_W'(MIN_HALF);
    localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(MAX_HALF);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(GOOD_CNT - 1);

    hb_state_t         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [GOOD_W-1:0] r_good;
    logic              r_alive;
    logic              r_fault;
    fault_code_t       r_code;

    logic w_pulse;
    logic w_fast;
    logic w_timeout;

    hb_edge_sync u_edge_sync (
        .iClk    (iClk),
        .iRst    (iRst),
        .i_async (hb.iHeartBeat),
        .o_pulse (w_pulse)
    );

    assign w_fast    = (r_cnt < MIN_C);
    assign w_timeout = (r_cnt == MAX_C) && !w_pulse;

    assign hb.oAlive     = r_alive;
    assign hb.oFault     = r_fault;
    assign hb.oFaultCode = r_code;
    assign hb.oEdgePulse = w_pulse;

    // r_cnt holds cycles elapsed since the last pulse, so the pulse cycle
    // itself loads 1 and an N-cycle half-period is judged with cnt == N.
    always_ff @(posedge iClk) begin
        if (iRst || hb.iClear) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_good  <= '0;
            r_alive <= 1'b0;
            r_fault <= 1'b0;
            r_code  <= FC_NONE;
        end else begin
            if (w_pulse) begin
                r_cnt <= CNT_ONE;
            end else if (r_cnt != MAX_C) begin
                r_cnt <= r_cnt + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_pulse) begin
                        r_state <= ST_ACQUIRE;
                        r_good  <= '0;
                    end else if (w_timeout) begin
                        r_state <= ST_FAULT;
                        r_fault <= 1'b1;
                        r_code  <= FC_TIMEOUT;
                    end
                end
                ST_ACQUIRE, ST_ALIVE: begin
                    if (w_pulse && w_fast) begin
                        r_state <= ST_FAULT;
                        r_fault <= 1'b1;
                        r_code  <= FC_FAST;
                        r_alive <= 1'b0;
                    end else if (w_pulse) begin
                        if (r_state == ST_ACQUIRE) begin
                            if (r_good == GOOD_LAST) begin
                                r_state <= ST_ALIVE;
                                r_alive <= 1'b1;
                            end else begin
                                r_good <= r_good + 1'b1;
                            end
                        end
                    end else if (w_timeout) begin
                        r_state <= ST_FAULT;
                        r_fault <= 1'b1;
                        r_code  <= FC_TIMEOUT;
                        r_alive <= 1'b0;
                    end
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Randomized bench for heartbeat_monitor with a timestamp-based reference model.
module tb_heartbeat_monitor;

    localparam int MIN_HALF = 8;
    localparam int MAX_HALF = 16;
    localparam int GOOD_CNT = 3;
    localparam int MAX_CYC  = 8192;

    typedef enum int {M_IDLE, M_ACQ, M_ALIVE, M_FAULT} m_state_t;

    logic iClk = 1'b0;
    logic iRst = 1'b1;

    heartbeat_monitor_if hb_if ();

    heartbeat_monitor #(
        .MIN_HALF (MIN_HALF),
        .MAX_HALF (MAX_HALF),
        .GOOD_CNT (GOOD_CNT)
    ) dut (
        .iClk (iClk),
        .iRst (iRst),
        .hb   (hb_if)
    );

    always #5 iClk = ~iClk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: effective sampled input per cycle, abstract state, time of last reference.
    bit       eff [0:MAX_CYC-1];
    m_state_t m_state = M_IDLE;
    int       m_ref   = 0;
    int       m_good  = 0;
    bit       e_pulse = 1'b0;
    bit       e_alive = 1'b0;
    bit       e_fault = 1'b0;
    logic [1:0] e_code = 2'b00;

    bit level = 1'b0;
    int last_pulse_cyc = -1000;
    int pulse_count    = 0;
    int fault_gap      = -1;
    int alive_gap      = -1;
    int alive_pulses   = -1;
    bit prev_fault     = 1'b0;
    bit prev_alive     = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic void enter_fault(input logic [1:0] code);
        m_state = M_FAULT;
        e_fault = 1'b1;
        e_code  = code;
        e_alive = 1'b0;
    endfunction

    // Expected outputs for the cycle following edge number cyc.
    function automatic void model_edge(input bit hb, input bit clr, input bit rst);
        int k;
        int elapsed;
        bit p;
        bit p_new;
        k       = cyc;
        p       = e_pulse;
        elapsed = (k - 1) - m_ref;
        if (elapsed > MAX_HALF) elapsed = MAX_HALF;
        eff[k] = rst ? 1'b0 : hb;
        if (rst) begin
            eff[k-1] = 1'b0;
            if (k >= 2) eff[k-2] = 1'b0;
        end
        p_new = (k >= 3) ? (eff[k-2] ^ eff[k-3]) : 1'b0;
        if (rst) begin
            m_state = M_IDLE; m_ref = k; m_good = 0;
            e_pulse = 1'b0; e_alive = 1'b0; e_fault = 1'b0; e_code = 2'b00;
        end else begin
            e_pulse = p_new;
            if (clr) begin
                m_state = M_IDLE; m_ref = k; m_good = 0;
                e_alive = 1'b0; e_fault = 1'b0; e_code = 2'b00;
            end else begin
                if (p) m_ref = k - 1;
                case (m_state)
                    M_IDLE: begin
                        if (p) begin
                            m_state = M_ACQ;
                            m_good  = 0;
                        end else if (elapsed == MAX_HALF) begin
                            enter_fault(2'b10);
                        end
                    end
                    M_ACQ, M_ALIVE: begin
                        if (p) begin
                            if (elapsed < MIN_HALF) begin
                                enter_fault(2'b01);
                            end else if (m_state == M_ACQ) begin
                                m_good++;
                                if (m_good == GOOD_CNT) begin
                                    m_state = M_ALIVE;
                                    e_alive = 1'b1;
                                end
                            end
                        end else if (elapsed == MAX_HALF) begin
                            enter_fault(2'b10);
                        end
                    end
                    default: ;
                endcase
            end
        end
    endfunction

    task automatic step(input bit hb, input bit clr, input bit rst);
        @(negedge iClk);
        hb_if.iHeartBeat = hb;
        hb_if.iClear     = clr;
        iRst             = rst;
        @(posedge iClk);
        #1;
        cyc++;
        model_edge(hb, clr, rst);
        check_val("edge_pulse", hb_if.oEdgePulse, e_pulse);
        check_val("alive", hb_if.oAlive, e_alive);
        check_val("fault", hb_if.oFault, e_fault);
        check_val("fault_code", hb_if.oFaultCode, e_code);
        if (hb_if.oFault === 1'b1 && !prev_fault) fault_gap = cyc - last_pulse_cyc;
        if (hb_if.oAlive === 1'b1 && !prev_alive) begin
            alive_gap    = cyc - last_pulse_cyc;
            alive_pulses = pulse_count;
        end
        if (hb_if.oEdgePulse === 1'b1) begin
            last_pulse_cyc = cyc;
            pulse_count++;
        end
        prev_fault = (hb_if.oFault === 1'b1);
        prev_alive = (hb_if.oAlive === 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) step(level, 1'b0, 1'b0);
    endtask

    // Toggle now; the next toggle_gap call toggles exactly n cycles later.
    task automatic toggle_gap(input int n);
        level = ~level;
        step(level, 1'b0, 1'b0);
        idle(n - 1);
    endtask

    task automatic acquire_until_alive(input string tag);
        pulse_count  = 0;
        alive_pulses = -1;
        for (int i = 0; i < 8; i++) begin
            if (hb_if.oAlive === 1'b1) break;
            toggle_gap(12);
        end
        check_val({tag, "_alive"}, hb_if.oAlive, 1);
        check_val({tag, "_pulses_to_alive"}, alive_pulses, 4);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        hb_if.iHeartBeat = 1'b0;
        hb_if.iClear     = 1'b0;

        repeat (3) step(1'b0, 1'b0, 1'b1);
        check_val("reset_alive", hb_if.oAlive, 0);
        check_val("reset_fault", hb_if.oFault, 0);
        check_val("reset_code", hb_if.oFaultCode, 0);

        // Steady 12-cycle half-periods.
        pulse_count = 0;
        repeat (6) toggle_gap(12);
        check_val("p1_alive", hb_if.oAlive, 1);
        check_val("p1_fault", hb_if.oFault, 0);
        check_val("p1_pulses_to_alive", alive_pulses, 4);
        check_val("p1_alive_gap", alive_gap, 1);

        // Stuck input.
        fault_gap = -1;
        for (int i = 0; i < 40; i++) begin
            if (hb_if.oFault === 1'b1) break;
            idle(1);
        end
        check_val("p2_fault", hb_if.oFault, 1);
        check_val("p2_timeout_gap", fault_gap, 17);
        check_val("p2_code", hb_if.oFaultCode, 2);
        check_val("p2_alive", hb_if.oAlive, 0);

        // Too-fast toggle while alive.
        step(level, 1'b1, 1'b0);
        check_val("p3_cleared", hb_if.oFault, 0);
        repeat (5) toggle_gap(12);
        fault_gap = -1;
        toggle_gap(5);
        toggle_gap(5);
        check_val("p3_fault", hb_if.oFault, 1);
        check_val("p3_code", hb_if.oFaultCode, 1);
        check_val("p3_fast_gap", fault_gap, 1);

        // Boundary intervals 8 and 16 legal, 7 too fast.
        step(level, 1'b1, 1'b0);
        toggle_gap(8);
        toggle_gap(16);
        toggle_gap(8);
        toggle_gap(16);
        toggle_gap(12);
        check_val("p4_no_fault", hb_if.oFault, 0);
        check_val("p4_alive", hb_if.oAlive, 1);
        fault_gap = -1;
        toggle_gap(7);
        toggle_gap(7);
        check_val("p4_fault", hb_if.oFault, 1);
        check_val("p4_code", hb_if.oFaultCode, 1);
        check_val("p4_fast_gap", fault_gap, 1);

        // Clear in the same cycle as a detected toggle.
        level = ~level;
        step(level, 1'b0, 1'b0);
        idle(2);
        check_val("p5_pulse_at_clear", hb_if.oEdgePulse, 1);
        step(level, 1'b1, 1'b0);
        check_val("p5_fault", hb_if.oFault, 0);
        check_val("p5_code", hb_if.oFaultCode, 0);
        check_val("p5_alive", hb_if.oAlive, 0);
        idle(11);
        acquire_until_alive("p5");

        // Reset while acquiring with good count 2.
        step(level, 1'b1, 1'b0);
        repeat (3) toggle_gap(12);
        check_val("p6_pre_alive", hb_if.oAlive, 0);
        level = 1'b0;
        step(level, 1'b0, 1'b1);
        check_val("p6_rst_alive", hb_if.oAlive, 0);
        check_val("p6_rst_fault", hb_if.oFault, 0);
        check_val("p6_rst_pulse", hb_if.oEdgePulse, 0);
        acquire_until_alive("p6");

        // Random mix of intervals, stalls, clears and resets.
        for (int seg = 0; seg < 160; seg++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 4) begin
                level = 1'($urandom_range(0, 1));
                step(level, 1'b0, 1'b1);
            end else if (r < 12) begin
                step(level, 1'b1, 1'b0);
            end else if (r < 20) begin
                idle($urandom_range(10, 30));
            end else begin
                toggle_gap($urandom_range(5, 18));
            end
        end
        idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
